string_atoi_parser: RTL and testbench

STRING_ATOI_PARSER -- requirements
Module: string_atoi_parser

---
 rtl/string_conv_pkg.sv | 31 +++
 rtl/char_digit_decode.sv | 41 ++++
 rtl/string_atoi_parser.sv | 143 ++++++++++++++
 tb/tb_string_atoi_parser.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/string_conv_pkg.sv
// Shared types and ASCII constants for the string-to-integer converter.
// Radix encoding matches the radix_sel port so it can be cast directly.
package string_conv_pkg;

    typedef enum logic [1:0] {
        RADIX_DEC = 2'd0,
        RADIX_HEX = 2'd1,
        RADIX_OCT = 2'd2,
        RADIX_BIN = 2'd3
    } radix_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SKIP  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ASCII_9          = 8'h39;
    localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_F    = 8'h66;
    localparam logic [7:0] ASCII_UPPER_A    = 8'h41;
    localparam logic [7:0] ASCII_UPPER_F    = 8'h46;
    localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;
    localparam logic [7:0] ASCII_MINUS      = 8'h2D;
    localparam logic [7:0] ASCII_PLUS       = 8'h2B;

    localparam logic [5:0] NDIG_MAX = 6'd63;

endpackage

// File: rtl/char_digit_decode.sv
// Combinational classifier: turns one ASCII character into a digit value
// and tells whether it is a legal digit for the selected radix.
module char_digit_decode
    import string_conv_pkg::*;
(
    input  logic [7:0] char_i,
    input  radix_e     radix_i,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_underscore
);

    logic is_num;
    logic is_lower_hex;
    logic is_upper_hex;

    always_comb begin
        is_num        = (char_i >= ASCII_0) && (char_i <= ASCII_9);
        is_lower_hex  = (char_i >= ASCII_LOWER_A) && (char_i <= ASCII_LOWER_F);
        is_upper_hex  = (char_i >= ASCII_UPPER_A) && (char_i <= ASCII_UPPER_F);
        is_underscore = (char_i == ASCII_UNDERSCORE);
        is_digit      = 1'b0;
        digit         = 4'd0;

        // Letters 'a'/'A' have low nibble 1, so adding 9 yields 10..15.
        if (is_num) begin
            digit = char_i[3:0];
        end else if (is_lower_hex || is_upper_hex) begin
            digit = char_i[3:0] + 4'd9;
        end

        case (radix_i)
            RADIX_DEC: is_digit = is_num;
            RADIX_HEX: is_digit = is_num || is_lower_hex || is_upper_hex;
            RADIX_OCT: is_digit = is_num && !char_i[3];
            RADIX_BIN: is_digit = is_num && (char_i[3:1] == 3'b000);
            default:   is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/string_atoi_parser.sv
// Streaming ASCII-to-integer converter for decimal, hex, octal and binary
// strings, with digit count, sticky overflow and optional decimal sign.
module string_atoi_parser
    import string_conv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       radix_sel,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    input  logic             char_last,
    output logic             char_ready,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic [5:0]       result_ndig,
    output logic             result_ovf
);

    state_e           state_q, state_d;
    radix_e           radix_q, radix_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [5:0]       ndig_q, ndig_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             first_q, first_d;

    logic             is_digit;
    logic [3:0]       digit;
    logic             is_underscore;
    logic             accept;
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] prod_ext;
    logic [WIDTH+3:0] sum_ext;

    char_digit_decode u_decode (
        .char_i        (char_data),
        .radix_i       (radix_q),
        .is_digit      (is_digit),
        .digit         (digit),
        .is_underscore (is_underscore)
    );

    // Four guard bits hold the full acc*16+15, so any nonzero guard bit
    // means the untruncated value did not fit in WIDTH bits.
    always_comb begin
        acc_ext  = {4'b0000, acc_q};
        prod_ext = '0;
        case (radix_q)
            RADIX_DEC: prod_ext = (acc_ext << 3) + (acc_ext << 1);
            RADIX_HEX: prod_ext = acc_ext << 4;
            RADIX_OCT: prod_ext = acc_ext << 3;
            RADIX_BIN: prod_ext = acc_ext << 1;
            default:   prod_ext = '0;
        endcase
        sum_ext = prod_ext + {{WIDTH{1'b0}}, digit};
    end

    assign char_ready = (state_q == ACCUM) || (state_q == SKIP);
    assign accept     = char_valid && char_ready;

    always_comb begin
        state_d = state_q;
        radix_d = radix_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        first_d = first_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    radix_d = radix_e'(radix_sel);
                    acc_d   = '0;
                    ndig_d  = '0;
                    ovf_d   = 1'b0;
                    neg_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (is_digit) begin
                        acc_d = sum_ext[WIDTH-1:0];
                        ovf_d = ovf_q | (|sum_ext[WIDTH+3:WIDTH]);
                        if (ndig_q != NDIG_MAX) begin
                            ndig_d = ndig_q + 6'd1;
                        end
                        if (char_last) state_d = DONE;
                    end else if (is_underscore) begin
                        if (char_last) state_d = DONE;
                    end else if ((radix_q == RADIX_DEC) && first_q &&
                                 ((char_data == ASCII_MINUS) || (char_data == ASCII_PLUS))) begin
                        // A leading sign only matters for decimal; '+' is a no-op.
                        if (char_data == ASCII_MINUS) neg_d = 1'b1;
                        if (char_last) state_d = DONE;
                    end else begin
                        state_d = char_last ? DONE : SKIP;
                    end
                end
            end
            SKIP: begin
                if (accept && char_last) state_d = DONE;
            end
            DONE: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            radix_q <= RADIX_DEC;
            acc_q   <= '0;
            ndig_q  <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            radix_q <= radix_d;
            acc_q   <= acc_d;
            ndig_q  <= ndig_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            first_q <= first_d;
        end
    end

    assign result_valid = (state_q == DONE);
    assign result       = neg_q ? (-acc_q) : acc_q;
    assign result_ndig  = ndig_q;
    assign result_ovf   = ovf_q;

endmodule

// File: tb/tb_string_atoi_parser.sv
// Bench for string_atoi_parser: directed table, multi-cycle corner
// sequences and random strings scored against an integer reference model.
module tb_string_atoi_parser;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       radix_sel;
    logic             char_valid;
    logic [7:0]       char_data;
    logic             char_last;
    logic             char_ready;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic [5:0]       result_ndig;
    logic             result_ovf;

    int vectors;
    int miscompares;

    logic [7:0]  str_q[$];
    logic        lat_ok;
    logic [31:0] got_result;
    logic [5:0]  got_ndig;
    logic        got_ovf;

    typedef struct {
        logic [1:0]  radix;
        string       str;
        logic [31:0] res;
        logic [5:0]  nd;
        logic        ov;
    } vec_t;

    vec_t tbl[16];

    string_atoi_parser #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .radix_sel    (radix_sel),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_last    (char_last),
        .char_ready   (char_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_ndig  (result_ndig),
        .result_ovf   (result_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got timeout, expected completion", name);
    endtask

    task automatic load_str(input string s);
        str_q.delete();
        if (s.len() == 0) begin
            str_q.push_back(8'h00);
        end else begin
            for (int i = 0; i < s.len(); i++) str_q.push_back(s[i]);
        end
    endtask

    function automatic int digit_of(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    // Reference: walk the string with plain integer arithmetic.
    function automatic void model(input logic [1:0] radix, output logic [31:0] r,
                                  output logic [5:0] nd, output logic ov);
        longint unsigned acc;
        longint unsigned full;
        int base;
        int d;
        int n;
        bit run;
        bit first;
        bit neg;
        base  = (radix == 2'd0) ? 10 : (radix == 2'd1) ? 16 : (radix == 2'd2) ? 8 : 2;
        acc   = 0;
        n     = 0;
        ov    = 1'b0;
        run   = 1'b1;
        first = 1'b1;
        neg   = 1'b0;
        foreach (str_q[i]) begin
            if (run) begin
                d = digit_of(str_q[i]);
                if (d >= 0 && d < base) begin
                    full = acc * 64'(base) + 64'(d);
                    if (full >= 64'h1_0000_0000) ov = 1'b1;
                    acc = full % 64'h1_0000_0000;
                    if (n < 63) n++;
                end else if (str_q[i] == 8'h5F) begin
                    run = 1'b1;
                end else if (base == 10 && first && str_q[i] == 8'h2D) begin
                    neg = 1'b1;
                end else if (base == 10 && first && str_q[i] == 8'h2B) begin
                    run = 1'b1;
                end else begin
                    run = 1'b0;
                end
                first = 1'b0;
            end
        end
        r  = neg ? 32'(64'd0 - acc) : 32'(acc);
        nd = 6'(n);
    endfunction

    task automatic applyStimulus(input logic [1:0] radix, input bit gaps, input int hold);
        int idx;
        int budget;
        logic [31:0] snap;
        idx    = 0;
        budget = 0;
        lat_ok = 1'b0;
        start     = 1'b1;
        radix_sel = radix;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (idx < int'(str_q.size()) && budget < 500) begin
            radix_sel = 2'($urandom_range(0, 3));
            if (gaps && $urandom_range(0, 2) == 0) begin
                char_valid = 1'b0;
            end else begin
                char_valid = 1'b1;
                char_data  = str_q[idx];
                char_last  = (idx == int'(str_q.size()) - 1);
                if (char_ready) idx++;
            end
            @(posedge clk);
            @(negedge clk);
            budget++;
        end
        char_valid = 1'b0;
        char_last  = 1'b0;
        char_data  = 8'h00;
        if (idx < int'(str_q.size())) fail_now("char accept");
        lat_ok = result_valid;
        snap   = result;
        for (int c = 0; c < hold; c++) begin
            start     = (c == 1);
            radix_sel = 2'($urandom_range(0, 3));
            check("hold valid", 64'(result_valid), 64'(1));
            check("hold result", 64'(result), 64'(snap));
            @(posedge clk);
            @(negedge clk);
        end
        start  = 1'b0;
        budget = 0;
        while (!result_valid && budget < 20) begin
            @(posedge clk);
            @(negedge clk);
            budget++;
        end
        if (!result_valid) fail_now("result_valid wait");
        got_result   = result;
        got_ndig     = result_ndig;
        got_ovf      = result_ovf;
        result_ready = 1'b1;
        start        = (hold > 0);
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        start        = 1'b0;
        if (hold > 0) check("start at handoff", 64'(char_ready), 64'(0));
    endtask

    task automatic checkOutput(input string name, input logic [31:0] er,
                               input logic [5:0] en, input logic eo);
        check({name, " latency"}, 64'(lat_ok), 64'(1));
        check({name, " result"},  64'(got_result), 64'(er));
        check({name, " ndig"},    64'(got_ndig), 64'(en));
        check({name, " ovf"},     64'(got_ovf), 64'(eo));
    endtask

    initial begin
        string zeros;
        logic [31:0] er;
        logic [5:0]  en;
        logic        eo;
        logic [1:0]  rx;
        int          len;
        int          pick;
        int          base;
        int          v;

        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        radix_sel    = 2'd0;
        char_valid   = 1'b0;
        char_data    = 8'h00;
        char_last    = 1'b0;
        result_ready = 1'b0;

        zeros = "";
        for (int i = 0; i < 70; i++) zeros = {zeros, "0"};

        tbl[0]  = '{2'd0, "1_234",      32'd1234,       6'd4,  1'b0};
        tbl[1]  = '{2'd1, "dEaD_bEeF",  32'hDEADBEEF,   6'd8,  1'b0};
        tbl[2]  = '{2'd0, "-42",        32'hFFFFFFD6,   6'd2,  1'b0};
        tbl[3]  = '{2'd2, "129",        32'd10,         6'd2,  1'b0};
        tbl[4]  = '{2'd2, "189",        32'd1,          6'd1,  1'b0};
        tbl[5]  = '{2'd3, "",           32'd0,          6'd0,  1'b0};
        tbl[6]  = '{2'd0, "4294967296", 32'd0,          6'd10, 1'b1};
        tbl[7]  = '{2'd1, "1FFFFFFFF",  32'hFFFFFFFF,   6'd9,  1'b1};
        tbl[8]  = '{2'd0, "+77",        32'd77,         6'd2,  1'b0};
        tbl[9]  = '{2'd3, "1011 x1",    32'd11,         6'd4,  1'b0};
        tbl[10] = '{2'd0, "--5",        32'd0,          6'd0,  1'b0};
        tbl[11] = '{2'd1, "-1",         32'd0,          6'd0,  1'b0};
        tbl[12] = '{2'd0, "12_-3",      32'd12,         6'd2,  1'b0};
        tbl[13] = '{2'd3, "_1_1",       32'd3,          6'd2,  1'b0};
        tbl[14] = '{2'd0, "_-5",        32'd0,          6'd0,  1'b0};
        tbl[15] = '{2'd0, zeros,        32'd0,          6'd63, 1'b0};

        #12;
        check("reset char_ready",   64'(char_ready), 64'(0));
        check("reset result_valid", 64'(result_valid), 64'(0));
        check("reset result",       64'(result), 64'(0));
        check("reset ndig",         64'(result_ndig), 64'(0));
        check("reset ovf",          64'(result_ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            load_str(tbl[i].str);
            applyStimulus(tbl[i].radix, 1'b0, 0);
            checkOutput($sformatf("vec%0d", i), tbl[i].res, tbl[i].nd, tbl[i].ov);
        end

        load_str("1_234");
        applyStimulus(2'd0, 1'b1, 0);
        checkOutput("gapped dec", 32'd1234, 6'd4, 1'b0);

        load_str("dEaD_bEeF");
        applyStimulus(2'd1, 1'b1, 5);
        checkOutput("backpressure hex", 32'hDEADBEEF, 6'd8, 1'b0);

        start     = 1'b1;
        radix_sel = 2'd0;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        char_valid = 1'b1;
        char_data  = 8'h31;
        char_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        char_data = 8'h32;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        check("mid ndig before reset", 64'(result_ndig), 64'(2));
        rst_n = 1'b0;
        #1;
        check("mid reset result",       64'(result), 64'(0));
        check("mid reset ndig",         64'(result_ndig), 64'(0));
        check("mid reset char_ready",   64'(char_ready), 64'(0));
        check("mid reset result_valid", 64'(result_valid), 64'(0));
        @(negedge clk);
        rst_n      = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h33;
        char_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        char_last  = 1'b0;
        check("idle char ignored valid", 64'(result_valid), 64'(0));
        check("idle char ignored ndig",  64'(result_ndig), 64'(0));
        load_str("7");
        applyStimulus(2'd0, 1'b0, 0);
        checkOutput("after reset", 32'd7, 6'd1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            rx   = 2'($urandom_range(0, 3));
            base = (rx == 2'd0) ? 10 : (rx == 2'd1) ? 16 : (rx == 2'd2) ? 8 : 2;
            len  = $urandom_range(1, 12);
            str_q.delete();
            for (int i = 0; i < len; i++) begin
                pick = $urandom_range(0, 19);
                if (pick < 13) begin
                    v = $urandom_range(0, base - 1);
                    if (v < 10) str_q.push_back(8'(8'h30 + v));
                    else if ($urandom_range(0, 1) == 1) str_q.push_back(8'(8'h61 + v - 10));
                    else str_q.push_back(8'(8'h41 + v - 10));
                end else if (pick < 15) begin
                    str_q.push_back(8'h5F);
                end else if (pick < 17) begin
                    str_q.push_back(($urandom_range(0, 1) == 1) ? 8'h2D : 8'h2B);
                end else begin
                    str_q.push_back(8'($urandom_range(0, 255)));
                end
            end
            model(rx, er, en, eo);
            applyStimulus(rx, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            checkOutput($sformatf("rand%0d", t), er, en, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
